fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter XLEN, default 64, data/address width.
REQ-002 Parameter INSTRUCTION_LENGTH, default 32, instruction width.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 Parameter NOP, default 32'h00000013, filler for empty window slots.
REQ-005 Parameter DEPTH, default 4, instruction buffer entries (>=3).
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 imem_req_valid  output  1  fetch request valid.
REQ-009 imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 imem_addr  output  XLEN  fetch address, word aligned.
REQ-011 imem_rsp_valid  input  1  response data valid.
REQ-012 imem_rsp_data  input  INSTRUCTION_LENGTH  fetched instruction.
REQ-013 f_to_d_enable_ff  input  1  1 = decode consumes head instruction this cycle.
REQ-014 redirect_valid  input  1  taken jump/branch; flush and refetch.
REQ-015 redirect_pc  input  XLEN  redirect target.
REQ-016 instruction  output  INSTRUCTION_LENGTH  buffer entry 0.
REQ-017 next_instruction  output  INSTRUCTION_LENGTH  buffer entry 1.
REQ-018 next_next_instruction  output  INSTRUCTION_LENGTH  buffer entry 2.
REQ-019 PC_out  output  XLEN  PC of entry 0.
REQ-020 instr_valid  output  1  entry 0 holds a real instruction.

Function
REQ-021 FSM states REQ, WAIT, DISCARD; at most one request outstanding.
REQ-022 REQ: imem_req_valid=1 iff count+1 <= DEPTH; on valid&&ready -> WAIT, fetch_pc += 4.
REQ-023 WAIT: on imem_rsp_valid push {fetch_pc-4, data} at tail -> REQ; visible on outputs next cycle.
REQ-024 DISCARD: on imem_rsp_valid drop data -> REQ; nothing pushed.
REQ-025 Pop head when f_to_d_enable_ff=1 and count>=1; f_to_d_enable_ff with count=0 is no-op.
REQ-026 Push and pop same cycle: count unchanged, order preserved.
REQ-027 Slots at index >= count drive NOP; instr_valid = (count>=1).
REQ-028 Redirect priority over push/pop/request: count<=0, fetch_pc<=redirect_pc with bits[1:0] forced 0.
REQ-029 Redirect in WAIT without same-cycle rsp, or in REQ with same-cycle handshake -> DISCARD.
REQ-030 Redirect in WAIT with same-cycle rsp_valid -> response dropped, -> REQ.
REQ-031 Redirect in REQ without handshake, or in DISCARD with rsp_valid -> REQ; in DISCARD without rsp -> stay DISCARD.
REQ-032 Request for redirect target asserted no earlier than cycle after redirect_valid.
REQ-033 fetch_pc increments modulo 2^XLEN (wraps to 0).
REQ-034 imem_addr = fetch_pc, stable while imem_req_valid=1 and imem_req_ready=0.
REQ-035 imem_rsp_valid outside WAIT/DISCARD ignored.

Reset
REQ-036 During rst: state<=REQ, count<=0, fetch_pc<=RESET_PC, pending redirect/response discarded.
REQ-037 Reset values: imem_req_valid=0 during rst, instruction/next/next_next=NOP, PC_out=RESET_PC, instr_valid=0.
REQ-038 First cycle after rst deassert: imem_req_valid=1, imem_addr=RESET_PC.
REQ-039 rst mid-WAIT: outstanding response arriving after reset ignored (REQ-035).

Verification
REQ-040 Reset, ready=1, 1-cycle rsp, f_to_d_enable_ff=0 -> buffer fills 0x0,0x4,0x8,0xC; request stops at count=4; outputs PC_out=0, three sequential words.
REQ-041 Steady stream with f_to_d_enable_ff=1 -> PC_out advances 0,4,8,...; next/next_next track head+1/+2 or NOP.
REQ-042 redirect_valid, redirect_pc=0x103 while WAIT -> late response dropped, next imem_addr=0x100, instr_valid=0 until 0x100 arrives.
REQ-043 redirect same cycle as rsp_valid -> response not in buffer; next request at target.
REQ-044 imem_req_ready held 0 five cycles -> imem_addr stable, no push, count unchanged.
REQ-045 RESET_PC=2^XLEN-4 -> second request imem_addr=0; rst asserted in WAIT -> stale rsp ignored, outputs return to reset values.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: one request channel
// (valid/ready/address) and one response channel (valid/data).
interface fetch_stage_if #(
    parameter int XLEN               = 64,
    parameter int INSTRUCTION_LENGTH = 32
);
    logic                          imem_req_valid;
    logic                          imem_req_ready;
    logic [XLEN-1:0]               imem_addr;
    logic                          imem_rsp_valid;
    logic [INSTRUCTION_LENGTH-1:0] imem_rsp_data;

    // Fetch stage side: issues requests, consumes responses.
    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Memory side: accepts requests, returns responses.
    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: issues one outstanding instruction-memory request at a time,
// queues returned words (with their PCs) in a small in-order buffer and
// exposes the first three entries to decode. A redirect flushes the buffer
// and restarts fetching at the (word-aligned) target; a response already in
// flight for the old path is dropped via the DISCARD state.
module fetch_stage #(
    parameter int                            XLEN               = 64,
    parameter int                            INSTRUCTION_LENGTH = 32,
    parameter logic [XLEN-1:0]               RESET_PC           = '0,
    parameter logic [INSTRUCTION_LENGTH-1:0] NOP                = 'h00000013,
    parameter int                            DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    fetch_stage_if.master                 imem,
    input  logic                          f_to_d_enable_ff,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic [INSTRUCTION_LENGTH-1:0] instruction,
    output logic [INSTRUCTION_LENGTH-1:0] next_instruction,
    output logic [INSTRUCTION_LENGTH-1:0] next_next_instruction,
    output logic [XLEN-1:0]               PC_out,
    output logic                          instr_valid
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [XLEN-1:0]               fetch_pc_q, fetch_pc_d;
    logic [INSTRUCTION_LENGTH-1:0] buf_instr_q [DEPTH];
    logic [INSTRUCTION_LENGTH-1:0] buf_instr_d [DEPTH];
    logic [XLEN-1:0]               buf_pc_q    [DEPTH];
    logic [XLEN-1:0]               buf_pc_d    [DEPTH];

    logic             req_valid;
    logic             handshake;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] wr_idx;

    // Request/handshake qualifiers; a request needs a free slot for its word.
    always_comb begin
        req_valid = !rst && (state_q == ST_REQ) && (count_q < CNT_W'(DEPTH));
        handshake = req_valid && imem.imem_req_ready;
        push      = (state_q == ST_WAIT) && imem.imem_rsp_valid && !redirect_valid;
        pop       = f_to_d_enable_ff && (count_q != '0);
        wr_idx    = count_q - CNT_W'(pop);
    end

    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = fetch_pc_q;

    // Next-state, fetch PC and buffer update; redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        fetch_pc_d = fetch_pc_q;
        for (int i = 0; i < DEPTH; i++) begin
            buf_instr_d[i] = buf_instr_q[i];
            buf_pc_d[i]    = buf_pc_q[i];
        end

        // Pop shifts every entry one place towards the head.
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                buf_instr_d[i] = buf_instr_q[i+1];
                buf_pc_d[i]    = buf_pc_q[i+1];
            end
            buf_instr_d[DEPTH-1] = NOP;
            buf_pc_d[DEPTH-1]    = '0;
        end

        // Push lands just behind the last surviving entry.
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    buf_instr_d[i] = imem.imem_rsp_data;
                    buf_pc_d[i]    = fetch_pc_q - XLEN'(4);
                end
            end
        end

        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            ST_REQ: begin
                if (handshake) begin
                    state_d    = ST_WAIT;
                    fetch_pc_d = fetch_pc_q + XLEN'(4);
                end
            end
            ST_WAIT: begin
                if (imem.imem_rsp_valid) state_d = ST_REQ;
            end
            ST_DISCARD: begin
                if (imem.imem_rsp_valid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase

        // A request still in flight after the redirect must be thrown away.
        if (redirect_valid) begin
            count_d    = '0;
            fetch_pc_d = redirect_pc & ~XLEN'(3);
            case (state_q)
                ST_REQ:     state_d = handshake ? ST_DISCARD : ST_REQ;
                ST_WAIT:    state_d = imem.imem_rsp_valid ? ST_REQ : ST_DISCARD;
                ST_DISCARD: state_d = imem.imem_rsp_valid ? ST_REQ : ST_DISCARD;
                default:    state_d = ST_REQ;
            endcase
        end

        if (rst) buf_pc_d[0] = RESET_PC;
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REQ;
            count_q    <= '0;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Buffer storage; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            buf_instr_q[i] <= buf_instr_d[i];
            buf_pc_q[i]    <= buf_pc_d[i];
        end
    end

    // Decode window: slots past the valid count show NOP.
    always_comb begin
        instruction           = (count_q > CNT_W'(0)) ? buf_instr_q[0] : NOP;
        next_instruction      = (count_q > CNT_W'(1)) ? buf_instr_q[1] : NOP;
        next_next_instruction = (count_q > CNT_W'(2)) ? buf_instr_q[2] : NOP;
        PC_out                = buf_pc_q[0];
        instr_valid           = (count_q != '0);
    end

endmodule
